// File: rtl/alu_cmd_driver.sv
// Sequential front end for a combinational N-bit ALU: registers commands into the ALU,
// samples result/flags after a settle window and returns them on a valid/ready response.
module alu_cmd_driver #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    output logic [3:0]   alu_op,
    output logic [N-1:0] alu_num1,
    output logic [N-1:0] alu_num2,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic [3:0]   rsp_flags,
    output logic         rsp_err,
    output logic [7:0]   rsp_count
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

    localparam logic [3:0] OP_DIV      = 4'd8;
    localparam logic [3:0] OP_MOD      = 4'd9;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   alu_op_q, alu_op_d;
    logic [N-1:0] alu_num1_q, alu_num1_d;
    logic [N-1:0] alu_num2_q, alu_num2_d;
    logic [N-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]   rsp_flags_q, rsp_flags_d;
    logic         rsp_err_q, rsp_err_d;
    logic [7:0]   count_q, count_d;

    always_comb begin
        // NOTE: every next-state value starts as its current value, so no branch leaves one unassigned (no latch).
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_op_d     = alu_op_q;
        alu_num1_d   = alu_num1_q;
        alu_num2_d   = alu_num2_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        count_d      = count_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op > OP_MOD) begin
                        // Illegal opcode never reaches the ALU; answer with an error immediately.
                        rsp_result_d = '0;
                        rsp_flags_d  = '0;
                        rsp_err_d    = 1'b1;
                        state_d      = S_RESP;
                    end else begin
                        alu_op_d   = cmd_op;
                        alu_num1_d = cmd_a;
                        alu_num2_d = cmd_b;
                        cnt_d      = '0;
                        state_d    = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == SETTLE_LAST) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    rsp_err_d    = ((alu_op_q == OP_DIV) || (alu_op_q == OP_MOD)) && (alu_num2_q == '0);
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    count_d = count_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            alu_op_q     <= '0;
            alu_num1_q   <= '0;
            alu_num2_q   <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_op_q     <= alu_op_d;
            alu_num1_q   <= alu_num1_d;
            alu_num2_q   <= alu_num2_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            count_q      <= count_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign alu_op     = alu_op_q;
    assign alu_num1   = alu_num1_q;
    assign alu_num2   = alu_num2_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_count  = count_q;
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: a behavioural 4-bit ALU closes the loop, expected responses
// are queued at command acceptance and compared when the response handshakes.
module tb_alu_cmd_driver;
    localparam int N      = 4;
    localparam int SETTLE = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic [3:0]   alu_op;
    logic [N-1:0] alu_num1;
    logic [N-1:0] alu_num2;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic         rsp_err;
    logic [7:0]   rsp_count;

    alu_cmd_driver #(.N(N), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_op     (alu_op),
        .alu_num1   (alu_num1),
        .alu_num2   (alu_num2),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .rsp_count  (rsp_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic [3:0] flags;
        logic       err;
    } vec_t;

    typedef struct {
        logic [3:0] res;
        logic [3:0] flags;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    vec_t       vecs[15];
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_count = 8'd0;
    logic [3:0] last_op = 4'd0;
    logic [3:0] last_a  = 4'd0;
    logic [3:0] last_b  = 4'd0;

    // Reference ALU: returns {result, Z, N, V, C}; C is carry for add, borrow for sub.
    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [7:0] p;
        logic [3:0] r;
        logic       v;
        logic       c;
        r = 4'd0;
        v = 1'b0;
        c = 1'b0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0];
                c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd1: begin
                r = a - b;
                c = (a < b);
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b;
            4'd6: r = a >> b;
            4'd7: begin
                p = {4'd0, a} * {4'd0, b};
                r = p[3:0];
                c = |p[7:4];
                v = c;
            end
            4'd8: r = (b == 4'd0) ? 4'd0 : a / b;
            4'd9: r = (b == 4'd0) ? 4'd0 : a % b;
            default: r = 4'd0;
        endcase
        return {r, (r == 4'd0), r[3], v, c};
    endfunction

    always_comb {alu_result, alu_flags} = alu_model(alu_op, alu_num1, alu_num2);

    function automatic exp_t exp_of(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        exp_t       e;
        logic [7:0] m;
        if (op > 4'd9) begin
            e.res   = 4'd0;
            e.flags = 4'd0;
            e.err   = 1'b1;
        end else begin
            m       = alu_model(op, a, b);
            e.res   = m[7:4];
            e.flags = m[3:0];
            e.err   = ((op == 4'd8) || (op == 4'd9)) && (b == 4'd0);
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Presents a command, waits (bounded) for acceptance and queues its expected response.
    task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input exp_t e);
        int w;
        w         = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
        end
        check("accept_wait", 32'(w < 50), 32'd1);
        sb.push_back(e);
        tick();
        cmd_valid = 1'b0;
        if (op <= 4'd9) begin
            last_op = op;
            last_a  = a;
            last_b  = b;
        end
    endtask

    // Waits for the response, compares it with the queue head, then handshakes it.
    task automatic receive(input string tag, input int exp_lat);
        int   w;
        exp_t e;
        w = 0;
        while (!rsp_valid && w < 50) begin
            tick();
            w++;
        end
        check({tag, "_latency"}, 32'(w), 32'(exp_lat));
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{4'd0, 4'd0, 1'b0};
        check({tag, "_result"}, 32'(rsp_result), 32'(e.res));
        check({tag, "_flags"}, 32'(rsp_flags), 32'(e.flags));
        check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
        check({tag, "_alu_op_held"}, 32'(alu_op), 32'(last_op));
        check({tag, "_alu_num1_held"}, 32'(alu_num1), 32'(last_a));
        check({tag, "_alu_num2_held"}, 32'(alu_num2), 32'(last_b));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_count = exp_count + 8'd1;
        check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_count"}, 32'(rsp_count), 32'(exp_count));
        check({tag, "_result_retained"}, 32'(rsp_result), 32'(e.res));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;

        vecs[0]  = '{4'd0, 4'd7, 4'd1, 4'h8, 4'b0110, 1'b0};  // add -> N,V
        vecs[1]  = '{4'd1, 4'd3, 4'd3, 4'h0, 4'b1000, 1'b0};  // sub -> Z
        vecs[2]  = '{4'd8, 4'd9, 4'd0, 4'h0, 4'b1000, 1'b1};  // div by zero
        vecs[3]  = '{4'd9, 4'd9, 4'd4, 4'h1, 4'b0000, 1'b0};  // mod
        vecs[4]  = '{4'd2, 4'hC, 4'hA, 4'h8, 4'b0100, 1'b0};  // and
        vecs[5]  = '{4'd3, 4'h5, 4'hA, 4'hF, 4'b0100, 1'b0};  // or
        vecs[6]  = '{4'd4, 4'hF, 4'hF, 4'h0, 4'b1000, 1'b0};  // xor
        vecs[7]  = '{4'd0, 4'hF, 4'h1, 4'h0, 4'b1001, 1'b0};  // add with carry out
        vecs[8]  = '{4'd1, 4'h2, 4'h5, 4'hD, 4'b0101, 1'b0};  // sub with borrow
        vecs[9]  = '{4'd7, 4'h5, 4'h4, 4'h4, 4'b0011, 1'b0};  // mul overflow
        vecs[10] = '{4'd9, 4'h9, 4'h0, 4'h0, 4'b1000, 1'b1};  // mod by zero
        vecs[11] = '{4'hC, 4'h3, 4'h3, 4'h0, 4'b0000, 1'b1};  // illegal opcode
        vecs[12] = '{4'd5, 4'h3, 4'h2, 4'hC, 4'b0100, 1'b0};  // shl
        vecs[13] = '{4'd6, 4'h8, 4'h3, 4'h1, 4'b0000, 1'b0};  // shr
        vecs[14] = '{4'd8, 4'h9, 4'h4, 4'h2, 4'b0000, 1'b0};  // div

        rst       = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_op    = 4'd0;
        cmd_a     = 4'd0;
        cmd_b     = 4'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_alu", {20'd0, alu_op, alu_num1, alu_num2}, 32'd0);
        check("reset_rsp", {23'd0, rsp_result, rsp_flags, rsp_err}, 32'd0);
        check("reset_count", 32'(rsp_count), 32'd0);

        // Idle with cmd_valid low and a stray rsp_ready: nothing may move.
        rsp_ready = 1'b1;
        repeat (3) tick();
        rsp_ready = 1'b0;
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_count", 32'(rsp_count), 32'd0);

        for (int i = 0; i < 15; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, '{vecs[i].res, vecs[i].flags, vecs[i].err});
            receive($sformatf("vec%0d", i), (vecs[i].op > 4'd9) ? 0 : SETTLE);
        end

        // Backpressure: response held for 5 cycles while a second command waits.
        send(4'd0, 4'd2, 4'd3, '{4'd5, 4'b0000, 1'b0});
        begin
            int w;
            w = 0;
            while (!rsp_valid && w < 50) begin
                tick();
                w++;
            end
            check("bp_latency", 32'(w), 32'(SETTLE));
        end
        cmd_valid = 1'b1;
        cmd_op    = 4'd4;
        cmd_a     = 4'd6;
        cmd_b     = 4'd3;
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_result", 32'(rsp_result), 32'd5);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_alu_op", 32'(alu_op), 32'd0);
            check("bp_alu_num1", 32'(alu_num1), 32'd2);
            tick();
        end
        receive("bp_first", 0);
        send(4'd4, 4'd6, 4'd3, '{4'd5, 4'b0000, 1'b0});
        receive("bp_second", SETTLE);

        // Reset while a command is in EXEC: it is dropped with no response.
        send(4'd7, 4'd3, 4'd3, exp_of(4'd7, 4'd3, 4'd3));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        exp_count = 8'd0;
        last_op   = 4'd0;
        last_a    = 4'd0;
        last_b    = 4'd0;
        check("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_exec_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_exec_alu", {20'd0, alu_op, alu_num1, alu_num2}, 32'd0);
        check("rst_exec_count", 32'(rsp_count), 32'd0);
        tick();
        check("rst_exec_no_rsp", 32'(rsp_valid), 32'd0);

        // 256 random commands (illegal opcodes included) wrap the response counter to 0.
        for (int i = 0; i < 256; i++) begin
            op = 4'($urandom_range(0, 11));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            if (i % 16 == 0) b = 4'd0;
            send(op, a, b, exp_of(op, a, b));
            receive($sformatf("rnd%0d", i), (op > 4'd9) ? 0 : SETTLE);
        end
        check("count_wrap", 32'(rsp_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
